// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding RV32 load/store unit between a CPU request/response port and a word-wide data memory.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned accesses with rsp_err instead of silently ignoring the low address bits.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_cen,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_data
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
  state_t state, state_nx;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        accept;
  logic        mis;
  logic        issue;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [31:0] st_data;
  logic [3:0]  st_mask;
  assign accept = req_valid && state == IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
  logic err_q;
  // funct3[1:0]: 00 byte, 01 halfword, anything else is a word access
  assign mis = req_funct3[1:0] == 2'b01 ? req_addr[0] :
               req_funct3[1:0] == 2'b00 ? 1'b0 : |req_addr[1:0];
  always_ff @(posedge clk or negedge reset)
    if (!reset) err_q <= 1'b0;
    else if (accept) err_q <= mis;
  assign rsp_err = rsp_valid && err_q;
`else
  assign mis     = 1'b0;
  assign rsp_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        rdata_q  <= '0;
      end
      if (state == CAPTURE) rdata_q <= ld_data;
    end
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req_valid) state_nx = mis ? RESP : ISSUE;
      ISSUE:   state_nx = we_q ? RESP : CAPTURE;
      CAPTURE: state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
    endcase
  end
  assign ld_byte = mem_data[{addr_q[1:0], 3'b000} +: 8];
  assign ld_half = addr_q[1] ? mem_data[31:16] : mem_data[15:0];
  assign ld_data = funct3_q == 3'b000 ? {{24{ld_byte[7]}}, ld_byte} :
                   funct3_q == 3'b001 ? {{16{ld_half[15]}}, ld_half} :
                   funct3_q == 3'b100 ? {24'd0, ld_byte} :
                   funct3_q == 3'b101 ? {16'd0, ld_half} : mem_data;
  assign st_data = funct3_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}} :
                   funct3_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
  assign st_mask = funct3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0] :
                   funct3_q[1:0] == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign issue     = state == ISSUE;
  assign req_ready = state == IDLE;
  assign mem_cen   = issue;
  assign mem_addr  = issue ? {addr_q[31:2], 2'b00} : '0;
  assign mem_wmask = issue && we_q ? st_mask : '0;
  assign mem_wdata = issue && we_q ? st_data : '0;
  assign rsp_valid = state == RESP;
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed bench for load_store_unit with a one-cycle-latency byte-masked memory model.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_cen;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_data;
  logic [31:0] mem [256];
  int          cen_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  logic        iss_cen;
  logic [31:0] iss_addr;
  logic [3:0]  iss_mask;
  logic [31:0] iss_wdata;

  load_store_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_cen(mem_cen), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_cen) begin
      for (int i = 0; i < 4; i++)
        if (mem_wmask[i]) mem[mem_addr[9:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
      mem_data <= mem[mem_addr[9:2]];
      cen_cnt  <= cen_cnt + 1;
    end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(output int n);
    n = 1;
    while (!rsp_valid && n < 8) begin
      tick;
      n++;
    end
  endtask

  task automatic present(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
  endtask

  // Full access with rsp_ready high; records the ISSUE-cycle memory outputs.
  task automatic run(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] d, input int exp_lat, input logic [31:0] exp_rdata);
    int n;
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    present(we, f3, a, d);
    tick;
    req_valid = 1'b0;
    iss_cen = mem_cen; iss_addr = mem_addr; iss_mask = mem_wmask; iss_wdata = mem_wdata;
    wait_rsp(n);
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
    chk({tag, "_err"}, 32'(rsp_err), 32'd0);
    tick;
  endtask

  logic [2:0]  ld_f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
  logic [31:0] ld_a   [5] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h101};
  logic [31:0] ld_exp [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8081, 32'h0000_7F01, 32'h0000_007F};

  initial begin
    int n;
    int c0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mem_cen", 32'(mem_cen), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    tick;
    #2 reset = 1'b1;
    tick;

    run("sw_init", 1'b1, 3'b010, 32'h100, 32'h8081_7F01, 2, 32'd0);
    chk("sw_init_cen", 32'(iss_cen), 32'd1);
    chk("sw_init_addr", iss_addr, 32'h100);
    chk("sw_init_mask", 32'(iss_mask), 32'hF);
    chk("sw_init_wdata", iss_wdata, 32'h8081_7F01);

    c0 = cen_cnt;
    run("lb_103", 1'b0, 3'b000, 32'h103, 32'd0, 3, 32'hFFFF_FF80);
    chk("lb_cen", 32'(iss_cen), 32'd1);
    chk("lb_addr", iss_addr, 32'h100);
    chk("lb_mask", 32'(iss_mask), 32'h0);
    chk("lb_cen_pulses", 32'(cen_cnt - c0), 32'd1);
    for (int i = 1; i < 5; i++)
      run($sformatf("load%0d", i), 1'b0, ld_f3[i], ld_a[i], 32'd0, 3, ld_exp[i]);

    run("sw_204", 1'b1, 3'b010, 32'h204, 32'd0, 2, 32'd0);
    run("sh_206", 1'b1, 3'b001, 32'h206, 32'h1234_ABCD, 2, 32'd0);
    chk("sh_mask", 32'(iss_mask), 32'hC);
    chk("sh_wdata", iss_wdata, 32'hABCD_ABCD);
    chk("sh_addr", iss_addr, 32'h204);
    run("sb_301", 1'b1, 3'b000, 32'h301, 32'h0000_005A, 2, 32'd0);
    chk("sb_mask", 32'(iss_mask), 32'h2);
    chk("sb_wdata", iss_wdata, 32'h5A5A_5A5A);
    run("sw_f3_7", 1'b1, 3'b111, 32'h300, 32'h1111_2222, 2, 32'd0);
    chk("sw_f3_7_mask", 32'(iss_mask), 32'hF);

    rsp_ready = 1'b0;
    present(1'b0, 3'b010, 32'h100, 32'd0);
    tick;
    present(1'b0, 3'b010, 32'h204, 32'd0);
    wait_rsp(n);
    chk("bp_latency", 32'(n), 32'd3);
    c0 = cen_cnt;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rdata", rsp_rdata, 32'h8081_7F01);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_mem_cen", 32'(mem_cen), 32'd0);
      tick;
    end
    chk("bp_no_issue", 32'(cen_cnt - c0), 32'd0);
    rsp_ready = 1'b1;
    chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
    tick;
    chk("bp_idle_ready", 32'(req_ready), 32'd1);
    tick;
    req_valid = 1'b0;
    chk("bp_next_cen", 32'(mem_cen), 32'd1);
    chk("bp_next_addr", mem_addr, 32'h204);
    wait_rsp(n);
    chk("bp_next_rdata", rsp_rdata, 32'hABCD_0000);
    tick;

    c0 = cen_cnt;
`ifdef LSU_MISALIGN_TRAP_EN
    present(1'b0, 3'b010, 32'h102, 32'd0);
    tick;
    req_valid = 1'b0;
    chk("mis_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("mis_err", 32'(rsp_err), 32'd1);
    chk("mis_rdata", rsp_rdata, 32'd0);
    tick;
    chk("mis_no_cen", 32'(cen_cnt - c0), 32'd0);
`else
    run("mis_lw_102", 1'b0, 3'b010, 32'h102, 32'd0, 3, 32'h8081_7F01);
    chk("mis_addr", iss_addr, 32'h100);
    chk("mis_cen_pulses", 32'(cen_cnt - c0), 32'd1);
`endif

    present(1'b0, 3'b010, 32'h100, 32'd0);
    tick;
    req_valid = 1'b0;
    tick;
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid_rdata", rsp_rdata, 32'd0);
    chk("rst_mid_mem_addr", mem_addr, 32'd0);
    tick;
    #2 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("rst_after_valid", 32'(rsp_valid), 32'd0);
      chk("rst_after_ready", 32'(req_ready), 32'd1);
    end

    run("b2b_sw", 1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF, 2, 32'd0);
    run("b2b_lw", 1'b0, 3'b010, 32'h40, 32'd0, 3, 32'hDEAD_BEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
